// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Counter width able to index every data bit; never narrower than one bit.
  function automatic int cnt_width(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Parallel request side and serial line side of the UART transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] i_p_data;
  logic                  i_data_valid;
  logic                  i_par_en;
  logic                  i_par_typ;
  logic                  o_tx_out;
  logic                  o_busy;

  modport master (
    output i_p_data,
    output i_data_valid,
    output i_par_en,
    output i_par_typ,
    input  o_tx_out,
    input  o_busy
  );

  modport slave (
    input  i_p_data,
    input  i_data_valid,
    input  i_par_en,
    input  i_par_typ,
    output o_tx_out,
    output o_busy
  );

endinterface

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity of a data word, even or odd selected by i_par_typ.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_parity
);

  logic xor_all;

  assign xor_all  = ^i_data;
  assign o_parity = (i_par_typ == PAR_ODD) ? ~xor_all : xor_all;

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame serialiser: start, LSB-first data, optional parity, stop.
// Clocked at one cycle per bit; line and busy are driven straight from flops.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  uart_tx_frame_if.slave  bus
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  uart_tx_state_e        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  par_bit;

  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .i_data    (data_q),
    .i_par_typ (par_typ_q),
    .o_parity  (par_bit)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // tx_d/busy_d describe the bit of the state being entered, so the
  // registered outputs line up with the state without a combinational path.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = LINE_IDLE;
    busy_d    = 1'b1;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.i_data_valid) begin
          state_d   = START;
          data_d    = bus.i_p_data;
          par_en_d  = bus.i_par_en;
          par_typ_d = bus.i_par_typ;
          tx_d      = START_BIT;
          busy_d    = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = data_q[0];
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit;
          end else begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_inc;
          tx_d  = data_q[cnt_inc];
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      STOP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.o_tx_out = tx_q;
  assign bus.o_busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: a frame-level model queues expected
// frames at acceptance; a line monitor rebuilds frames and compares them.
module tb_uart_tx_frame;

  localparam int W = 8;

  typedef struct {
    int          start;
    int          len;
    logic [15:0] bits;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_WIDTH(W)) bus ();

  uart_tx_frame #(.DATA_WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int free_at = 0;
  int cur_len = 0;
  int cur_start = 0;
  logic [15:0] cur = '0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Expected serial frame, index 0 = first bit on the line.
  function automatic frame_t model_frame(input int acc, input logic [W-1:0] d,
                                         input logic pe, input logic pt);
    frame_t f;
    f.start = acc + 1;
    f.bits  = '0;
    f.len   = pe ? W + 3 : W + 2;
    f.bits[0] = 1'b0;
    for (int i = 0; i < W; i++) f.bits[1+i] = d[i];
    if (pe) f.bits[W+1] = (($countones(d) + (pt ? 1 : 0)) % 2) == 1;
    f.bits[f.len-1] = 1'b1;
    return f;
  endfunction

  // Model: a request is taken when the transmitter is free; it is free again
  // one idle cycle after the frame ends.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
        free_at = 0;
      end else if (bus.i_data_valid === 1'b1 && cyc >= free_at) begin
        exp_q.push_back(model_frame(cyc, bus.i_p_data, bus.i_par_en, bus.i_par_typ));
        free_at = cyc + (bus.i_par_en ? W + 3 : W + 2) + 1;
      end
      cyc = cyc + 1;
    end
  end

  initial begin
    frame_t f;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_len = 0;
      end else if (bus.o_busy === 1'b1) begin
        if (cur_len == 0) begin
          cur_start = cyc;
          cur = '0;
        end
        if (cur_len < 16) cur[cur_len] = bus.o_tx_out;
        cur_len++;
      end else begin
        check(bus.o_busy === 1'b0 && bus.o_tx_out === 1'b1, "idle_line",
              int'(bus.o_tx_out), 1);
        if (cur_len > 0) begin
          $display("frame start=%0d len=%0d bits=%h", cur_start, cur_len, cur);
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_frame", cur_start, -1);
          end else begin
            f = exp_q.pop_front();
            check(cur_start == f.start, "frame_start", cur_start, f.start);
            check(cur_len == f.len, "frame_len", cur_len, f.len);
            check(cur === f.bits, "frame_bits", int'(cur), int'(f.bits));
          end
          cur_len = 0;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic pe, input logic pt);
    @(negedge clk);
    bus.i_p_data = d;
    bus.i_par_en = pe;
    bus.i_par_typ = pt;
    bus.i_data_valid = 1'b1;
    @(negedge clk);
    bus.i_data_valid = 1'b0;
    repeat (W + 4) @(negedge clk);
  endtask

  initial begin
    bus.i_p_data = '0;
    bus.i_par_en = 1'b0;
    bus.i_par_typ = 1'b0;
    bus.i_data_valid = 1'b0;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check(bus.o_tx_out === 1'b1, "reset_tx", int'(bus.o_tx_out), 1);
    check(bus.o_busy === 1'b0, "reset_busy", int'(bus.o_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(8'hA5, 1'b0, 1'b0);
    send(8'hA5, 1'b1, 1'b0);
    send(8'hA5, 1'b1, 1'b1);
    send(8'h01, 1'b1, 1'b1);

    // Data change and a second valid pulse while a frame is in flight.
    @(negedge clk);
    bus.i_p_data = 8'hA5;
    bus.i_par_en = 1'b0;
    bus.i_data_valid = 1'b1;
    @(negedge clk);
    bus.i_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.i_p_data = 8'hFF;
    bus.i_data_valid = 1'b1;
    @(negedge clk);
    bus.i_data_valid = 1'b0;
    repeat (W + 4) @(negedge clk);

    // Valid held high: frames every W+3 cycles.
    @(negedge clk);
    bus.i_p_data = 8'h3C;
    bus.i_par_en = 1'b0;
    bus.i_data_valid = 1'b1;
    repeat (40) @(negedge clk);
    bus.i_data_valid = 1'b0;
    repeat (W + 4) @(negedge clk);

    // Reset asserted between edges while data bit 3 is on the line.
    @(negedge clk);
    bus.i_p_data = 8'hA5;
    bus.i_data_valid = 1'b1;
    @(negedge clk);
    bus.i_data_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check(bus.o_tx_out === 1'b1, "midreset_tx", int'(bus.o_tx_out), 1);
    check(bus.o_busy === 1'b0, "midreset_busy", int'(bus.o_busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'h55, 1'b0, 1'b0);

    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      bus.i_p_data = W'($urandom);
      bus.i_par_en = 1'($urandom);
      bus.i_par_typ = 1'($urandom);
      bus.i_data_valid = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    bus.i_data_valid = 1'b0;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && cur_len == 0) break;
    end
    check(exp_q.size() == 0 && cur_len == 0, "drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
